// File: rtl/aec_lms_sequencer_if.sv
// Control/handshake bundle between the LMS sequencer, the sample input stage,
// the coefficient/history RAMs and the shared MAC datapath.
interface aec_lms_sequencer_if #(
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   spk_sample;
    logic          adapt_en;
    logic          dtd;
    logic          hist_we;
    logic [AW-1:0] hist_wr_addr;
    logic [15:0]   hist_wr_data;
    logic          rd_en;
    logic [AW-1:0] coef_rd_addr;
    logic [AW-1:0] hist_rd_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          err_ld;
    logic          upd_mode;
    logic          coef_we;
    logic [AW-1:0] coef_wr_addr;
    logic          coef_wr_zero;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [15:0]   frozen_cnt;

    // Handshakes: a transfer happens in a cycle where valid and ready are both 1
    // at the rising edge; valid, once raised, holds until that transfer.
    modport master (
        input  in_valid, spk_sample, adapt_en, dtd, out_ready,
        output in_ready, hist_we, hist_wr_addr, hist_wr_data, rd_en,
               coef_rd_addr, hist_rd_addr, acc_clr, acc_en, err_ld, upd_mode,
               coef_we, coef_wr_addr, coef_wr_zero, out_valid, busy, frozen_cnt
    );

    modport slave (
        output in_valid, spk_sample, adapt_en, dtd, out_ready,
        input  in_ready, hist_we, hist_wr_addr, hist_wr_data, rd_en,
               coef_rd_addr, hist_rd_addr, acc_clr, acc_en, err_ld, upd_mode,
               coef_we, coef_wr_addr, coef_wr_zero, out_valid, busy, frozen_cnt
    );
endinterface

// File: rtl/aec_lms_sequencer.sv
// Per-sample LMS echo-canceller sequencer: coefficient zero-init, FIR pass,
// error latch and optional coefficient update on one shared MAC.
module aec_lms_sequencer #(
    parameter int TAPS = 16,
    parameter int AW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    aec_lms_sequencer_if.master  bus
);
    localparam int KW = AW + 1;

    typedef enum logic [3:0] {
        S_RST,
        S_INIT,
        S_IDLE,
        S_SHIFT,
        S_FILT,
        S_FLUSH,
        S_ERR,
        S_UPD,
        S_WAIT_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   spk_q, spk_d;
    logic          adapt_q, adapt_d;
    logic          acc_en_q, acc_en_d;
    logic          out_pend_q, out_pend_d;
    logic [15:0]   frozen_q, frozen_d;
    logic          out_hs;

    // S_RST keeps every strobe low while reset is held; INIT starts on the
    // first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RST;
            k_q        <= '0;
            wr_ptr_q   <= '0;
            spk_q      <= '0;
            adapt_q    <= 1'b0;
            acc_en_q   <= 1'b0;
            out_pend_q <= 1'b0;
            frozen_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wr_ptr_q   <= wr_ptr_d;
            spk_q      <= spk_d;
            adapt_q    <= adapt_d;
            acc_en_q   <= acc_en_d;
            out_pend_q <= out_pend_d;
            frozen_q   <= frozen_d;
        end
    end

    assign out_hs = out_pend_q & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wr_ptr_d   = wr_ptr_q;
        spk_d      = spk_q;
        adapt_d    = adapt_q;
        acc_en_d   = (state_q == S_FILT);
        out_pend_d = out_pend_q & ~out_hs;
        frozen_d   = frozen_q;
        case (state_q)
            S_RST: begin
                state_d = S_INIT;
                k_d     = '0;
            end
            S_INIT: begin
                if (k_q == KW'(TAPS - 1)) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.in_valid) begin
                    spk_d   = bus.spk_sample;
                    adapt_d = bus.adapt_en & ~bus.dtd;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                state_d = S_FILT;
                k_d     = '0;
            end
            S_FILT: begin
                if (k_q == KW'(TAPS - 1)) begin
                    state_d = S_FLUSH;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_FLUSH: state_d = S_ERR;
            S_ERR: begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                out_pend_d = 1'b1;
                k_d        = '0;
                if (adapt_q) begin
                    state_d = S_UPD;
                end else begin
                    state_d = S_WAIT_OUT;
                    if (frozen_q != 16'hFFFF) frozen_d = frozen_q + 1'b1;
                end
            end
            // One extra cycle past the last read lets the final write-back land.
            S_UPD: begin
                if (k_q == KW'(TAPS)) begin
                    k_d     = '0;
                    state_d = (out_hs || !out_pend_q) ? S_IDLE : S_WAIT_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WAIT_OUT: begin
                if (out_hs || !out_pend_q) state_d = S_IDLE;
            end
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        bus.in_ready     = (state_q == S_IDLE);
        bus.busy         = (state_q != S_IDLE);
        bus.hist_we      = (state_q == S_SHIFT);
        bus.hist_wr_addr = wr_ptr_q;
        bus.hist_wr_data = spk_q;
        bus.acc_clr      = (state_q == S_SHIFT);
        bus.acc_en       = acc_en_q;
        bus.err_ld       = (state_q == S_ERR);
        bus.upd_mode     = (state_q == S_UPD);
        bus.out_valid    = out_pend_q;
        bus.frozen_cnt   = frozen_q;
        bus.rd_en        = 1'b0;
        bus.coef_rd_addr = '0;
        bus.hist_rd_addr = '0;
        bus.coef_we      = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_zero = 1'b0;
        case (state_q)
            S_INIT: begin
                bus.coef_we      = 1'b1;
                bus.coef_wr_addr = k_q[AW-1:0];
                bus.coef_wr_zero = 1'b1;
            end
            S_FILT: begin
                bus.rd_en        = 1'b1;
                bus.coef_rd_addr = k_q[AW-1:0];
                bus.hist_rd_addr = wr_ptr_q - k_q[AW-1:0];
            end
            // wr_ptr has already advanced, so step back one to revisit FILT's taps.
            S_UPD: begin
                if (!k_q[AW]) begin
                    bus.rd_en        = 1'b1;
                    bus.coef_rd_addr = k_q[AW-1:0];
                    bus.hist_rd_addr = wr_ptr_q - AW'(1) - k_q[AW-1:0];
                end
                if (k_q != '0) begin
                    bus.coef_we      = 1'b1;
                    bus.coef_wr_addr = k_q[AW-1:0] - AW'(1);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_aec_lms_sequencer.sv
// Directed bench for aec_lms_sequencer at TAPS=4: init, filter/update timing,
// history wrap, double-talk freeze, output backpressure and mid-run reset.
module tb_aec_lms_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    aec_lms_sequencer_if #(.AW(2)) bus ();

    aec_lms_sequencer #(.TAPS(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {hist_we, acc_clr, rd_en, acc_en, err_ld, upd_mode, coef_we, out_valid, in_ready}
    function automatic logic [8:0] strobes();
        return {bus.hist_we, bus.acc_clr, bus.rd_en, bus.acc_en, bus.err_ld,
                bus.upd_mode, bus.coef_we, bus.out_valid, bus.in_ready};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if (strobes() !== 9'b0 || bus.frozen_cnt !== 16'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold: strobes=%b frozen=%h busy=%b, want 000000000 0000 1",
                     strobes(), bus.frozen_cnt, bus.busy);
        end
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            total++;
            if (strobes() !== 9'b000000100 || bus.coef_wr_zero !== 1'b1 ||
                bus.coef_wr_addr !== 2'(c - 1)) begin
                bad++;
                $display("FAIL init_cycle%0d: strobes=%b zero=%b addr=%0d, want 000000100 1 %0d",
                         c, strobes(), bus.coef_wr_zero, bus.coef_wr_addr, c - 1);
            end
        end
        step();
        total++;
        if (strobes() !== 9'b000000001 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL init_idle: strobes=%b busy=%b, want 000000001 0", strobes(), bus.busy);
        end
    endtask

    // Starts in IDLE with out_ready=1; ends in IDLE at the in_ready cycle.
    task automatic run_sample(input logic [15:0] spk, input logic ad, input logic dt,
                              input logic [1:0] wr, input string name);
        logic [7:0] seq;
        logic       upd;
        int         last;
        logic [8:0] exp_s;
        int         k;
        case (wr)
            2'd0: seq = 8'b00_11_10_01;
            2'd1: seq = 8'b01_00_11_10;
            2'd2: seq = 8'b10_01_00_11;
            default: seq = 8'b11_10_01_00;
        endcase
        upd  = ad & ~dt;
        last = upd ? 13 : 9;
        bus.in_valid   = 1'b1;
        bus.spk_sample = spk;
        bus.adapt_en   = ad;
        bus.dtd        = dt;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_accept_ready: in_ready=%b, want 1", name, bus.in_ready);
        end
        step();
        bus.in_valid   = 1'b0;
        bus.spk_sample = ~spk;
        bus.adapt_en   = ~ad;
        bus.dtd        = ~dt;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) step();
            exp_s = {c == 1, c == 1,
                     (c >= 2 && c <= 5) || (upd && c >= 8 && c <= 11),
                     c >= 3 && c <= 6, c == 7,
                     upd && c >= 8 && c <= 12,
                     upd && c >= 9 && c <= 12,
                     c == 8, c == last};
            total++;
            if (strobes() !== exp_s) begin
                bad++;
                $display("FAIL %s_strobes_T+%0d: got %b, want %b", name, c, strobes(), exp_s);
            end
            if (c == 1) begin
                total++;
                if (bus.hist_wr_addr !== wr || bus.hist_wr_data !== spk) begin
                    bad++;
                    $display("FAIL %s_hist_write: addr=%0d data=%h, want %0d %h",
                             name, bus.hist_wr_addr, bus.hist_wr_data, wr, spk);
                end
            end
            if (exp_s[6]) begin
                k = (c <= 5) ? c - 2 : c - 8;
                total++;
                if (bus.coef_rd_addr !== 2'(k) || bus.hist_rd_addr !== seq[7-2*k -: 2]) begin
                    bad++;
                    $display("FAIL %s_rd_T+%0d: coef=%0d hist=%0d, want %0d %0d",
                             name, c, bus.coef_rd_addr, bus.hist_rd_addr, k, seq[7-2*k -: 2]);
                end
            end
            if (exp_s[2]) begin
                total++;
                if (bus.coef_wr_addr !== 2'(c - 9) || bus.coef_wr_zero !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_coef_wr_T+%0d: addr=%0d zero=%b, want %0d 0",
                             name, c, bus.coef_wr_addr, bus.coef_wr_zero, c - 9);
                end
            end
        end
    endtask

    task automatic check_frozen(input logic [15:0] exp, input string name);
        total++;
        if (bus.frozen_cnt !== exp) begin
            bad++;
            $display("FAIL %s: frozen_cnt=%0d, want %0d", name, bus.frozen_cnt, exp);
        end
    endtask

    task automatic test_wrap();
        run_sample(16'h0101, 1'b1, 1'b0, 2'd1, "wrap1");
        run_sample(16'h0202, 1'b0, 1'b0, 2'd2, "wrap2_noadapt");
        run_sample(16'h0303, 1'b1, 1'b0, 2'd3, "wrap3");
        run_sample(16'hBEEF, 1'b1, 1'b0, 2'd0, "wrap4_fifth");
        check_frozen(16'd1, "wrap_frozen");
    endtask

    task automatic test_dtd();
        run_sample(16'h7FFF, 1'b1, 1'b1, 2'd1, "dtd");
        check_frozen(16'd2, "dtd_frozen");
    endtask

    task automatic test_backpressure();
        int wr_cnt = 0;
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.spk_sample = 16'hA5A5;
        bus.adapt_en   = 1'b1;
        bus.dtd        = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) step();
        for (int c = 8; c <= 28; c++) begin
            step();
            if (bus.coef_we) wr_cnt++;
            bus.in_valid = (c < 28);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.hist_we !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_T+%0d: out_valid=%b in_ready=%b hist_we=%b, want 1 0 0",
                         c, bus.out_valid, bus.in_ready, bus.hist_we);
            end
        end
        bus.out_ready = 1'b1;
        step();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || wr_cnt != 4) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b coef_writes=%0d, want 1 0 4",
                     bus.in_ready, bus.out_valid, wr_cnt);
        end
        check_frozen(16'd2, "bp_frozen");
    endtask

    task automatic test_reset_mid();
        bus.in_valid   = 1'b1;
        bus.spk_sample = 16'h1111;
        bus.adapt_en   = 1'b1;
        bus.dtd        = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        total++;
        if (strobes() !== 9'b0) begin
            bad++;
            $display("FAIL mid_reset_strobes: got %b, want 000000000", strobes());
        end
        test_reset();
        check_frozen(16'd0, "mid_reset_frozen");
        run_sample(16'h2222, 1'b1, 1'b0, 2'd0, "after_reset");
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.spk_sample = '0;
        bus.adapt_en   = 1'b0;
        bus.dtd        = 1'b0;
        bus.out_ready  = 1'b1;
        test_reset();
        run_sample(16'h1234, 1'b1, 1'b0, 2'd0, "first");
        test_wrap();
        test_dtd();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
